// File: rtl/seq_mult_pkg.sv
// seq_mult_pkg: shared types and sizing helpers for the digit-serial multiplier.
package seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Accumulator width: one operand, one digit and a sign/guard bit.
  function automatic int acc_width(input int p, input int max_width);
    return max_width + p + 1;
  endfunction

  // Number of P-bit digits in a full-width operand.
  function automatic int digit_count(input int p, input int max_width);
    return max_width / p;
  endfunction

endpackage

// File: rtl/seq_mult_stream_if.sv
// seq_mult_stream_if: operand input handshake and product digit stream.
// master drives operands and consumes digits; slave is the multiplier.
interface seq_mult_stream_if #(
  parameter int P         = 2,
  parameter int MAX_WIDTH = 16
);
  localparam int NW = $clog2(MAX_WIDTH / P) + 1;

  logic                 in_valid;
  logic                 in_ready;
  logic [MAX_WIDTH-1:0] a;
  logic [MAX_WIDTH-1:0] b;
  logic [NW-1:0]        bitSize;
  logic                 signed_mode;
  logic                 abort;
  logic                 out_valid;
  logic                 out_ready;
  logic [P-1:0]         out_data;
  logic                 out_last;

  modport master (
    output in_valid, a, b, bitSize, signed_mode, abort, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, a, b, bitSize, signed_mode, abort, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

endinterface

// File: rtl/seq_mult_stream_digit_mac_row.sv
// digit_mac_row: combinational acc + a_ext * d for one P-bit digit of b.
// With i_neg_digit set the digit is taken as two's complement (d - 2^P when
// its MSB is set), which gives the top digit of a signed operand its weight.
// All arithmetic is modulo 2^AW, which is exact for two's-complement values.
module digit_mac_row
  import seq_mult_pkg::*;
#(
  parameter int P         = 2,
  parameter int MAX_WIDTH = 16
) (
  input  logic [acc_width(P, MAX_WIDTH)-1:0] i_acc,
  input  logic [acc_width(P, MAX_WIDTH)-1:0] i_a_ext,
  input  logic [P-1:0]                       i_digit,
  input  logic                               i_neg_digit,
  output logic [acc_width(P, MAX_WIDTH)-1:0] o_sum
);
  localparam int AW = acc_width(P, MAX_WIDTH);

  logic [AW-1:0] w_d_ext;
  logic [AW-1:0] w_prod;

  assign w_d_ext = {{(AW - P){i_neg_digit & i_digit[P-1]}}, i_digit};
  assign w_prod  = i_a_ext * w_d_ext;
  assign o_sum   = i_acc + w_prod;

endmodule

// File: rtl/seq_mult_stream.sv
// seq_mult_stream: digit-serial self-sequencing multiplier. One P-bit digit of
// b is multiplied against a per cycle and the 2*N*P-bit product is streamed
// LSB-first, one digit per cycle, with valid/ready on both sides.
// Optional feature macro: SEQ_MULT_SIGNED_EN (honours signed_mode; when
// undefined every operation is unsigned).
//
// state | meaning
// IDLE  | in_ready high, waiting for an operation
// MUL   | presenting digits 0..N-1, accumulating a_ext * d_k
// DRAIN | presenting digits N..2N-1, shifting out the accumulator
//
// Digit 0 is computed in the accept cycle from the live operands so that it is
// already registered on out_data in the following cycle; each later digit is
// computed when the presented one transfers.
module seq_mult_stream
  import seq_mult_pkg::*;
#(
  parameter int P         = 2,
  parameter int MAX_WIDTH = 16
) (
  input logic              clk,
  input logic              rst_n,
  seq_mult_stream_if.slave bus
);
  localparam int AW = acc_width(P, MAX_WIDTH);
  localparam int ND = digit_count(P, MAX_WIDTH);
  localparam int NW = $clog2(ND) + 1;
  localparam int KW = NW + 1;
  localparam logic [NW-1:0] ND_W = NW'(ND);

  state_t          r_state;
  logic [AW-1:0]   r_a_ext;
  logic [AW-1:0]   r_acc;
  logic [MAX_WIDTH-1:0] r_b;
  logic [NW-1:0]   r_n;
  logic            r_signed;
  logic [KW-1:0]   r_k;
  logic            r_out_valid;
  logic [P-1:0]    r_out_data;
  logic            r_out_last;

  logic w_sgn_in;
`ifdef SEQ_MULT_SIGNED_EN
  assign w_sgn_in = bus.signed_mode;
`else
  logic w_unused_signed_mode;
  assign w_unused_signed_mode = bus.signed_mode;
  assign w_sgn_in = 1'b0;
`endif

  // N clamping and masking/extension of the incoming a operand.
  logic [NW-1:0] w_n_in;
  logic [AW-1:0] w_mask;
  logic [AW-1:0] w_mask_top;
  logic [AW-1:0] w_a_masked;
  logic [AW-1:0] w_a_ext_in;

  assign w_n_in     = (bus.bitSize == '0 || bus.bitSize > ND_W) ? ND_W : bus.bitSize;
  assign w_mask     = ~({AW{1'b1}} << (w_n_in * P));
  assign w_mask_top = w_mask ^ (w_mask >> 1);
  assign w_a_masked = {{(AW - MAX_WIDTH){1'b0}}, bus.a} & w_mask;
  assign w_a_ext_in = (w_sgn_in && |(w_a_masked & w_mask_top)) ?
                      (w_a_masked | ~w_mask) : w_a_masked;

  // Digit counter bookkeeping; w_k_next is the digit about to be computed.
  logic [KW-1:0] w_k_next;
  logic [KW-1:0] w_k_last;
  logic [KW-1:0] w_k_top;
  logic          w_in_mul_range;
  logic [P-1:0]  w_b_digit;

  assign w_k_next       = r_k + KW'(1);
  assign w_k_last       = {r_n, 1'b0} - KW'(1);
  assign w_k_top        = {1'b0, r_n} - KW'(1);
  assign w_in_mul_range = (w_k_next < {1'b0, r_n});
  assign w_b_digit      = P'(r_b >> (w_k_next * P));

  logic          w_idle;
  logic [AW-1:0] w_mac_acc;
  logic [AW-1:0] w_mac_a;
  logic [P-1:0]  w_mac_d;
  logic          w_mac_neg;
  logic [AW-1:0] w_acc_next;
  logic          w_sgn_sel;
  logic [AW-1:0] w_acc_shr;

  assign w_idle    = (r_state == IDLE);
  assign w_mac_acc = w_idle ? '0 : r_acc;
  assign w_mac_a   = w_idle ? w_a_ext_in : r_a_ext;
  assign w_mac_d   = w_idle ? bus.b[P-1:0] : (w_in_mul_range ? w_b_digit : '0);
  assign w_mac_neg = w_idle ? (w_sgn_in && w_n_in == NW'(1))
                            : (r_signed && w_k_next == w_k_top);

  digit_mac_row #(
    .P         (P),
    .MAX_WIDTH (MAX_WIDTH)
  ) u_mac (
    .i_acc       (w_mac_acc),
    .i_a_ext     (w_mac_a),
    .i_digit     (w_mac_d),
    .i_neg_digit (w_mac_neg),
    .o_sum       (w_acc_next)
  );

  assign w_sgn_sel = w_idle ? w_sgn_in : r_signed;
  assign w_acc_shr = {{P{w_sgn_sel & w_acc_next[AW-1]}}, w_acc_next[AW-1:P]};

  // Sequencer: accept, per-digit step on transfer, abort, and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_a_ext     <= '0;
      r_acc       <= '0;
      r_b         <= '0;
      r_n         <= '0;
      r_signed    <= 1'b0;
      r_k         <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_a_ext     <= w_a_ext_in;
            r_b         <= bus.b;
            r_n         <= w_n_in;
            r_signed    <= w_sgn_in;
            r_k         <= '0;
            r_acc       <= w_acc_shr;
            r_out_data  <= w_acc_next[P-1:0];
            r_out_valid <= 1'b1;
            r_out_last  <= 1'b0;
            r_state     <= MUL;
          end
        end
        MUL, DRAIN: begin
          if (bus.abort) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
          end else if (bus.out_ready) begin
            if (r_k == w_k_last) begin
              r_state     <= IDLE;
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
            end else begin
              r_k        <= w_k_next;
              r_acc      <= w_acc_shr;
              r_out_data <= w_acc_next[P-1:0];
              r_out_last <= (w_k_next == w_k_last);
              if (r_state == MUL && w_k_next == {1'b0, r_n}) begin
                r_state <= DRAIN;
              end
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = w_idle;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_last  = r_out_last;

endmodule

// File: doc/seq_mult_stream.md
# seq_mult_stream

Digit-serial, self-sequencing multiplier: the parametrised successor of the externally sequenced 2-bit serial multiplier. Each operation takes two operands of up to MAX_WIDTH bits, multiplies one P-bit digit of b per cycle against the full operand a, and streams the 2·N·P-bit product LSB-first, one P-bit digit per cycle. It supports any power-of-two P, an internal FSM in place of external mux and count controls, valid/ready handshaking on both sides, and an optional signed mode. It sits in the datapath wherever the serial multiplier was instantiated.

## Interface
- P, 2: digit width in bits; power of two, 1 ≤ P ≤ MAX_WIDTH.
- MAX_WIDTH, 16: maximum operand width; a multiple of P.
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operands and mode are valid.
- in_ready  out  1  block is idle and can accept an operation.
- a  in  MAX_WIDTH  multiplier operand; bits above N·P are ignored.
- b  in  MAX_WIDTH  multiplicand operand; bits above N·P are ignored.
- bitSize  in  $clog2(MAX_WIDTH/P)+1  operand length N in digits.
- signed_mode  in  1  1 = two's-complement operands.
- abort  in  1  synchronous cancel of the current operation.
- out_valid  out  1  out_data holds a product digit.
- out_ready  in  1  consumer accepts the digit.
- out_data  out  P  product digit, LSB-first.
- out_last  out  1  marks digit 2N−1.

## Operation
- FSM states: IDLE, MUL, DRAIN.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready, latch a, b, N and signed_mode, clear the accumulator and digit counter k, then go to MUL.
- N clamping: bitSize = 0 or bitSize > MAX_WIDTH/P latches N = MAX_WIDTH/P.
- Operand extension: a_ext is a masked to N·P bits, then extended to MAX_WIDTH+P+1 bits (sign-extended when signed, zero-extended otherwise).
- MUL, for k = 0..N−1: acc_next = acc + a_ext·d_k, where d_k = b[kP+P−1:kP].
  - In signed mode the top digit d_{N−1} is weighted negatively (d − 2^P when its MSB is 1).
- DRAIN, for k = N..2N−1: acc_next = acc.
- Per-cycle output and shift (both MUL and DRAIN):
  - out_data = acc_next[P−1:0], registered.
  - The accumulator shifts right by P: arithmetic when signed, logical otherwise.
- Transitions:
  - MUL→DRAIN after digit N−1 transfers.
  - DRAIN→IDLE after digit 2N−1 transfers.
- Result: the output is the exact product modulo 2^(2NP). Accumulator width MAX_WIDTH+P+1 guarantees no overflow.
- Backpressure: out_valid & !out_ready freezes acc, k, state, out_data and out_last.
- abort:
  - In MUL or DRAIN, abort drops the operation. Next cycle: state IDLE, out_valid = 0, in_ready = 1.
  - abort in IDLE is ignored. abort takes priority over a simultaneous out transfer.
- Reset: asynchronous at any time. State IDLE; acc, k and operand registers 0; out_valid 0, out_data 0, out_last 0. in_ready is 1 once reset is released.

## Timing
- Accept in cycle t. The first digit is valid in t+1.
- With out_ready held high, digit i is valid in t+1+i. The last digit is valid in t+2N.
- in_ready is 1 in the cycle after the final transfer. There is no overlap between operations.
- Throughput is 2N+1 cycles per operation. Every stall cycle adds exactly one cycle.
- out_data, out_valid and out_last are registered outputs; nothing combinational runs from out_ready to out_valid.
- in_ready depends only on state.

## Configuration
- SEQ_MULT_SIGNED_EN defined: signed_mode is honoured (sign extension, negative top-digit weight, arithmetic shift).
- Not defined: signed_mode is ignored and all operations are unsigned. The negative-weight logic and the sign extension are not synthesised.

## Structure
- Package seq_mult_pkg holds:
  - the state enum typedef (IDLE, MUL, DRAIN);
  - the accumulator-width function (MAX_WIDTH+P+1);
  - the digit-count function (MAX_WIDTH/P).
- One sub-module, digit_mac_row. It is combinational: acc + a_ext·d, with a signed-digit flag, parametrised on P and MAX_WIDTH.
- The FSM, counters and registers stay in seq_mult_stream.

## Test plan
All scenarios use P=2, MAX_WIDTH=16.
1. Unsigned: N=4, a=0xB7, b=0x5A → product 0x4056. Digits 2,1,1,1,0,0,0,1; out_last on the 8th digit; first digit at accept+1.
2. Signed: N=4, a=0xFD, b=0x05, signed_mode=1 → product 0xFFF1. Digits 1,0,3,3,3,3,3,3. Build without SEQ_MULT_SIGNED_EN → product 0x04F1, digits 1,0,3,3,0,1,0,0.
3. Full width: N=8, a=b=0xFFFF unsigned → product 0xFFFE0001. Digits 1,0,0,0,0,0,0,0,2,3,3,3,3,3,3,3. bitSize=0 gives the identical result.
4. Backpressure: scenario 1 with out_ready low for 3 cycles while digit 2 is presented → out_data holds 1 throughout. Sequence is unchanged; last digit at accept+11.
5. abort asserted while the 3rd digit is presented → out_valid 0 and in_ready 1 next cycle. A new operation (scenario 1) then produces the correct digits.
6. rst_n low mid-DRAIN → out_valid, out_data and out_last read 0 immediately. After release, in_ready is 1 and scenario 2 passes.
